// File: rtl/serial_mag_compare_pkg.sv
// Shared result encoding and FSM states for the bit-serial magnitude comparator.
// Result words are one-hot over [0:2]: y[0]=GT, y[1]=EQ, y[2]=LT.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic [0:2] Y_NONE = 3'b000;
    localparam logic [0:2] Y_GT   = 3'b100;
    localparam logic [0:2] Y_EQ   = 3'b010;
    localparam logic [0:2] Y_LT   = 3'b001;

endpackage

// File: rtl/serial_mag_compare_bit_cmp.sv
// Single-bit magnitude comparator: one-hot GT/EQ/LT of a against b.
module bit_cmp
    import cmp_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [0:2] y
);

    always_comb begin
        if (a == b) begin
            y = Y_EQ;
        end else if (a) begin
            y = Y_GT;
        end else begin
            y = Y_LT;
        end
    end

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial word comparator: latches two operands on start, walks them MSB-first
// through bit_cmp and publishes a one-hot GT/EQ/LT result with a done pulse.
module serial_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             busy,
    output logic             done,
    output logic [0:2]       y
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [0:2]       dec_q, dec_d;
    logic [0:2]       y_q, y_d;
    logic             done_q, done_d;

    logic [0:2]       bit_y;
    logic             bit_diff;
    logic             last_bit;
    logic             finish;

    bit_cmp u_bit_cmp (
        .a (a_q[idx_q]),
        .b (b_q[idx_q]),
        .y (bit_y)
    );

    assign bit_diff = (bit_y != Y_EQ);
    assign last_bit = (idx_q == '0);
    assign finish   = (state_q == SCAN) && (last_bit || (EARLY_EXIT && bit_diff));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = SCAN;
            SCAN:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
        done = done_q;
        y    = y_q;
    end

    // The decision register keeps the first differing bit; later bits cannot overwrite it.
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        dec_d  = dec_q;
        y_d    = y_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d   = a_word;
                b_d   = b_word;
                idx_d = IDX_MSB;
                dec_d = Y_EQ;
            end
        end else begin
            if ((dec_q == Y_EQ) && bit_diff) begin
                dec_d = bit_y;
            end
            if (finish) begin
                done_d = 1'b1;
                y_d    = (dec_q == Y_EQ) ? bit_y : dec_q;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            dec_q  <= Y_EQ;
            y_q    <= Y_NONE;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            dec_q  <= dec_d;
            y_q    <= y_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Randomised bench for serial_mag_compare: an early-exit and a constant-latency
// instance share stimulus and are checked every cycle against a latency/result model.
module tb_serial_mag_compare;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_word = '0;
    logic [W-1:0] b_word = '0;

    logic         busy_e, done_e, busy_f, done_f;
    logic [0:2]   y_e, y_f;

    int n_cmp = 0;
    int n_err = 0;

    // index 0: EARLY_EXIT=1 instance, index 1: EARLY_EXIT=0 instance
    bit         mb[2];
    bit         md[2];
    int         mcnt[2];
    logic [2:0] mres[2];
    logic [2:0] my[2];

    always #5 clk = ~clk;

    serial_mag_compare #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_word (a_word),
        .b_word (b_word),
        .busy   (busy_e),
        .done   (done_e),
        .y      (y_e)
    );

    serial_mag_compare #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_word (a_word),
        .b_word (b_word),
        .busy   (busy_f),
        .done   (done_f),
        .y      (y_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic int ref_latency(input bit early, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!early) return W;
        for (int k = W - 1; k >= 0; k--) begin
            if (a[k] != b[k]) return W - k;
        end
        return W;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; md[i] = 0; mcnt[i] = 0; mres[i] = 3'b000; my[i] = 3'b000;
        end
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) begin
                md[i] = 0;
                if (mb[i]) begin
                    mcnt[i]--;
                    if (mcnt[i] == 0) begin
                        mb[i] = 0;
                        md[i] = 1;
                        my[i] = mres[i];
                    end
                end else if (start) begin
                    mb[i]   = 1;
                    mcnt[i] = ref_latency(i == 0, a_word, b_word);
                    mres[i] = ref_result(a_word, b_word);
                end
            end
        end
        #1;
        if (rst_n) begin
            chk("ee_busy", 32'(busy_e), 32'(mb[0]));
            chk("ee_done", 32'(done_e), 32'(md[0]));
            chk("ee_y",    32'(y_e),    32'(my[0]));
            chk("full_busy", 32'(busy_f), 32'(mb[1]));
            chk("full_done", 32'(done_f), 32'(md[1]));
            chk("full_y",    32'(y_f),    32'(my[1]));
        end
    end

    task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start  = s;
        a_word = a;
        b_word = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ee_busy"},   32'(busy_e), 32'd0);
        chk({tag, "_ee_done"},   32'(done_e), 32'd0);
        chk({tag, "_ee_y"},      32'(y_e),    32'd0);
        chk({tag, "_full_busy"}, 32'(busy_f), 32'd0);
        chk({tag, "_full_done"}, 32'(done_f), 32'd0);
        chk({tag, "_full_y"},    32'(y_f),    32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Equal operands, MSB difference, LSB difference
        step(1'b1, 8'hA5, 8'hA5); idle(10);
        step(1'b1, 8'h80, 8'h7F); idle(10);
        step(1'b1, 8'h12, 8'h13); idle(10);

        // start held during SCAN with changing operands, then back-to-back accepts
        step(1'b1, 8'h12, 8'h13);
        for (int i = 0; i < 20; i++) step(1'b1, 8'hFF, 8'h00);
        idle(10);

        // Asynchronous reset in the middle of a scan
        step(1'b1, 8'hA5, 8'hA5);
        idle(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        #2 rst_n = 1'b1;
        step(1'b1, 8'h3C, 8'h3D); idle(10);

        // Randomised traffic, biased towards equal and near-equal operands
        for (int n = 0; n < 400; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            step($urandom_range(0, 2) == 0, ra, rb);
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_mag_compare.md
# serial_mag_compare

Bit-serial multi-bit magnitude comparator built around the team's single-bit comparator. It latches two WIDTH-bit operands on a start strobe and walks them MSB-first, one bit per clock, through a 1-bit compare stage. It accumulates the per-bit greater/equal/less flags into a one-hot word result with a done pulse. It sits directly downstream of the 1-bit comparator and consumes its y[0:2] output, extending it to words.

## Interface
- WIDTH, 8: operand width in bits. Must be ≥ 1.
- EARLY_EXIT, 1:
  - 1: finish at the first differing bit.
  - 0: always scan all WIDTH bits, giving constant latency.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a compare; sampled only in IDLE.
- a_word  input  WIDTH  operand A; latched when start is accepted.
- b_word  input  WIDTH  operand B; latched when start is accepted.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when y is updated.
- y  output  [0:2]  one-hot result, held until the next result or reset:
  - y[0]: A > B
  - y[1]: A == B
  - y[2]: A < B

## Operation
- Reset (asynchronous, any time including mid-scan):
  - state = IDLE, index = 0
  - busy = 0, done = 0, y = 3'b000 (no result yet)
  - latched operands cleared
- IDLE:
  - On start = 1: latch a_word and b_word, set index = WIDTH-1, go to SCAN.
  - done stays 0 in the accept cycle.
- SCAN: each cycle, bit_cmp compares a_q[index] with b_q[index].
  - EARLY_EXIT=1, bit pair differs: y is set to the bit result (GT or LT), done = 1, go to IDLE.
  - Bits equal and index = 0: y = EQ, done = 1, go to IDLE.
  - Otherwise: index decrements and SCAN continues.
- SCAN with EARLY_EXIT=0:
  - The first differing bit is recorded in an internal decision register, starting at EQ.
  - Later bits never overwrite it.
  - At index = 0, y is set from the decision register, done = 1, go to IDLE.
- Rules on start and operands:
  - start during SCAN is ignored, not queued.
  - Operand changes after acceptance are ignored.
- y is exactly one-hot after the first completed compare. y = 3'b000 occurs only after reset.

## Timing
- Edge E0 samples start in IDLE. The first SCAN edge is E1 and evaluates bit WIDTH-1.
- Latency from E0 to the done edge:
  - EARLY_EXIT=1: WIDTH-k cycles, where k is the index of the most significant differing bit. Equal operands take WIDTH cycles.
  - EARLY_EXIT=0: always WIDTH cycles.
- busy is high from after E0 until after the done edge. done and the new y appear on the same edge that busy falls.
- done is high for exactly one cycle. The FSM is back in IDLE in that cycle.
- Back-to-back operation: start held high during the done cycle is accepted at the next edge, so there is no dead cycle.
- WIDTH = 1: a single SCAN cycle; latency 1.
- The index counter is max($clog2(WIDTH),1) bits. It never wraps, because SCAN exits at index 0.

## Structure
- Package cmp_pkg holds:
  - Result constants: Y_NONE = 3'b000, Y_GT = 3'b100, Y_EQ = 3'b010, Y_LT = 3'b001 (MSB is y[0]).
  - FSM state encoding: IDLE, SCAN.
- One sub-module, bit_cmp: purely combinational, inputs a and b, output y[0:2] using the same one-hot encoding. Instantiate it once, fed with a_q[index] and b_q[index].
- Top level holds the FSM, index counter, operand registers, decision register and output registers.

## Test plan
- Equal operands, WIDTH=8, EARLY_EXIT=1: a=8'hA5, b=8'hA5, start pulse. Required: busy high for 8 cycles, then done pulse with y=3'b010.
- MSB differs: a=8'h80, b=8'h7F. Required: done 1 cycle after acceptance with y=3'b100. Then a=8'h12, b=8'h13 (LSB differs). Required: done after 8 cycles with y=3'b001.
- EARLY_EXIT=0: a=8'h80, b=8'h7F. Required: done exactly 8 cycles after acceptance, y=3'b100, no early done.
- Start is not re-sampled in SCAN; operand changes ignored: run a=8'h12, b=8'h13 and, during SCAN, drive a=8'hFF, b=8'h00 with start held high every cycle. Required: single done with y=3'b001. Because start is still high in the done cycle, a second compare (a=8'hFF, b=8'h00) is accepted at the next edge, with done 1 cycle later and y=3'b100.
- Back-to-back: start held high across two compares. Required: the second acceptance happens at the edge right after done, with no idle gap.
- Async reset mid-scan: deassert rst_n for half a cycle during SCAN. Required: busy=0, done=0 and y=3'b000 immediately, before any clock edge. The next start runs a full fresh compare.
